// File: rtl/bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bus_pkg : shared state type and constants for the bus arbiter      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;

endpackage
`default_nettype wire

// File: rtl/bus_arb_select.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bus_arb_select : combinational winner pick, fixed or rotating      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module bus_arb_select #(
    parameter  int NPORTS = 3,
    localparam int GW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic [NPORTS-1:0] req_i,
    input  logic [GW-1:0]     ptr_i,
    input  logic              rr_mode_i,
    output logic [GW-1:0]     idx_o,
    output logic              valid_o
);

    logic [GW-1:0]       w_start;
    logic [2*NPORTS-1:0] w_dbl;
    logic [NPORTS-1:0]   w_rot;
    logic [GW-1:0]       w_off;
    logic [GW:0]         w_sum;

    // Rotate so the search always starts at bit 0, then undo the rotation.
    assign w_start = rr_mode_i ? ptr_i : '0;
    assign w_dbl   = {req_i, req_i} >> w_start;
    assign w_rot   = w_dbl[NPORTS-1:0];

    always_comb begin
        w_off = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = GW'(k);
            end
        end
    end

    assign w_sum   = {1'b0, w_start} + {1'b0, w_off};
    assign idx_o   = (w_sum >= (GW+1)'(NPORTS)) ? GW'(w_sum - (GW+1)'(NPORTS))
                                                 : w_sum[GW-1:0];
    assign valid_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/bus_arbiter_n.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bus_arbiter_n : N-master to single-slave arbiter with timeout abort |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module bus_arbiter_n
    import bus_pkg::*;
#(
    parameter  int NPORTS   = 3,
    parameter  int ARB_MODE = ARB_FIXED,
    parameter  int TIMEOUT  = 1024,
    parameter  int AW       = BUS_AW,
    parameter  int DW       = BUS_DW,
    localparam int GW       = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [NPORTS-1:0]    i_m_request,
    input  logic [NPORTS-1:0]    i_m_rw,
    input  logic [NPORTS*AW-1:0] i_m_address,
    input  logic [NPORTS*DW-1:0] i_m_wdata,
    output logic [NPORTS-1:0]    o_m_ready,
    output logic [NPORTS*DW-1:0] o_m_rdata,
    output logic [NPORTS-1:0]    o_m_error,
    output logic                 o_bus_request,
    output logic                 o_bus_rw,
    output logic [AW-1:0]        o_bus_address,
    output logic [DW-1:0]        o_bus_wdata,
    input  logic                 i_bus_ready,
    input  logic [DW-1:0]        i_bus_rdata,
    output logic [GW-1:0]        o_grant
);

    localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic          RR_MODE = (ARB_MODE == ARB_RR);

    state_e              state_q;
    logic [GW-1:0]       grant_q;
    logic [GW-1:0]       ptr_q;
    logic [GW-1:0]       ptr_d;
    logic [CW-1:0]       cnt_q;
    logic                rw_q;
    logic [AW-1:0]       addr_q;
    logic [DW-1:0]       wdata_q;
    logic                bus_req_q;
    logic [NPORTS-1:0]   ready_q;
    logic [NPORTS-1:0]   error_q;
    logic [NPORTS*DW-1:0] rdata_q;

    logic [GW-1:0]       w_sel_idx;
    logic                w_sel_valid;
    logic                w_timeout_hit;

    bus_arb_select #(
        .NPORTS (NPORTS)
    ) u_select (
        .req_i     (i_m_request),
        .ptr_i     (ptr_q),
        .rr_mode_i (RR_MODE),
        .idx_o     (w_sel_idx),
        .valid_o   (w_sel_valid)
    );

    assign ptr_d         = (grant_q == GW'(NPORTS - 1)) ? '0 : grant_q + GW'(1);
    assign w_timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            bus_req_q <= 1'b0;
            ready_q   <= '0;
            error_q   <= '0;
            rdata_q   <= '0;
        end else begin
            ready_q <= '0;
            error_q <= '0;
            case (state_q)
                IDLE: begin
                    if (w_sel_valid) begin
                        grant_q   <= w_sel_idx;
                        rw_q      <= i_m_rw[w_sel_idx];
                        addr_q    <= i_m_address[w_sel_idx*AW +: AW];
                        wdata_q   <= i_m_wdata[w_sel_idx*DW +: DW];
                        cnt_q     <= '0;
                        bus_req_q <= 1'b1;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    // A ready arriving on the expiry cycle still counts as success.
                    if (i_bus_ready) begin
                        ready_q[grant_q] <= 1'b1;
                        if (!rw_q) begin
                            rdata_q[grant_q*DW +: DW] <= i_bus_rdata;
                        end
                        bus_req_q <= 1'b0;
                        state_q   <= RELEASE;
                    end else if (w_timeout_hit) begin
                        ready_q[grant_q]          <= 1'b1;
                        error_q[grant_q]          <= 1'b1;
                        rdata_q[grant_q*DW +: DW] <= '0;
                        bus_req_q                 <= 1'b0;
                        state_q                   <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RELEASE: begin
                    if (RR_MODE) begin
                        ptr_q <= ptr_d;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_m_ready     = ready_q;
    assign o_m_error     = error_q;
    assign o_m_rdata     = rdata_q;
    assign o_bus_request = bus_req_q;
    assign o_bus_rw      = rw_q;
    assign o_bus_address = addr_q;
    assign o_bus_wdata   = wdata_q;
    assign o_grant       = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_n.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_bus_arbiter_n : fixed-priority and round-robin arbiter bench     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_bus_arbiter_n;

    localparam int NP = 3;
    localparam int C_TO [2] = '{16, 8};
    localparam int C_RR [2] = '{0, 1};

    logic        clk = 1'b0;
    logic        rst    [2] = '{1'b1, 1'b1};
    logic [2:0]  req    [2] = '{3'b0, 3'b0};
    logic [2:0]  rw     [2] = '{3'b0, 3'b0};
    logic [95:0] addr   [2] = '{96'h0, 96'h0};
    logic [95:0] wdat   [2] = '{96'h0, 96'h0};
    logic [2:0]  m_rdy  [2];
    logic [2:0]  m_err  [2];
    logic [95:0] m_rd   [2];
    logic        breq   [2];
    logic        brw    [2];
    logic [31:0] baddr  [2];
    logic [31:0] bwd    [2];
    logic [1:0]  gnt    [2];

    logic        slv_rdy   [2] = '{1'b0, 1'b0};
    logic        slv_force [2] = '{1'b0, 1'b0};
    logic [31:0] slv_rd    [2] = '{32'h0, 32'h0};
    int          slv_lat   [2] = '{0, 0};
    int          slv_cnt   [2] = '{0, 0};

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    int  glog0 [$];
    int  glog1 [$];
    int  rise1 [$];
    logic bprev [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    bus_arbiter_n #(.NPORTS(NP), .ARB_MODE(0), .TIMEOUT(16), .AW(32), .DW(32)) u_fx (
        .i_clock(clk), .i_reset(rst[0]), .i_m_request(req[0]), .i_m_rw(rw[0]),
        .i_m_address(addr[0]), .i_m_wdata(wdat[0]), .o_m_ready(m_rdy[0]),
        .o_m_rdata(m_rd[0]), .o_m_error(m_err[0]), .o_bus_request(breq[0]),
        .o_bus_rw(brw[0]), .o_bus_address(baddr[0]), .o_bus_wdata(bwd[0]),
        .i_bus_ready(slv_rdy[0] | slv_force[0]), .i_bus_rdata(slv_rd[0]), .o_grant(gnt[0]));

    bus_arbiter_n #(.NPORTS(NP), .ARB_MODE(1), .TIMEOUT(8), .AW(32), .DW(32)) u_rr (
        .i_clock(clk), .i_reset(rst[1]), .i_m_request(req[1]), .i_m_rw(rw[1]),
        .i_m_address(addr[1]), .i_m_wdata(wdat[1]), .o_m_ready(m_rdy[1]),
        .o_m_rdata(m_rd[1]), .o_m_error(m_err[1]), .o_bus_request(breq[1]),
        .o_bus_rw(brw[1]), .o_bus_address(baddr[1]), .o_bus_wdata(bwd[1]),
        .i_bus_ready(slv_rdy[1] | slv_force[1]), .i_bus_rdata(slv_rd[1]), .o_grant(gnt[1]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- transaction-level reference model ----------------
    int          m_act [2], m_age [2], m_cool [2], m_ptr [2], m_g [2];
    logic [2:0]  e_rdy [2], e_err [2];
    logic        e_breq [2], e_rw [2];
    logic [31:0] e_addr [2], e_wd [2];
    logic [31:0] e_rd [2][NP];

    function automatic void mdl_reset(input int d);
        m_act[d] = 0; m_age[d] = 0; m_cool[d] = 0; m_ptr[d] = 0; m_g[d] = 0;
        e_rdy[d] = '0; e_err[d] = '0; e_breq[d] = 1'b0; e_rw[d] = 1'b0;
        e_addr[d] = '0; e_wd[d] = '0;
        for (int p = 0; p < NP; p++) e_rd[d][p] = '0;
    endfunction

    function automatic void mdl_finish(input int d, input bit err);
        m_act[d] = 0; m_cool[d] = 1; e_breq[d] = 1'b0;
        e_rdy[d][m_g[d]] = 1'b1;
        e_err[d][m_g[d]] = err;
    endfunction

    function automatic void mdl_step(input int d);
        e_rdy[d] = '0;
        e_err[d] = '0;
        if (m_cool[d] != 0) begin
            m_cool[d] = 0;
            if (C_RR[d] != 0) m_ptr[d] = (m_g[d] + 1) % NP;
        end else if (m_act[d] == 0) begin
            bit found;
            found = 1'b0;
            for (int o = 0; o < NP; o++) begin
                int p;
                p = (m_ptr[d] + o) % NP;
                if (!found && req[d][p]) begin
                    found = 1'b1;
                    m_g[d] = p;
                    e_rw[d] = rw[d][p];
                    e_addr[d] = addr[d][p*32 +: 32];
                    e_wd[d] = wdat[d][p*32 +: 32];
                end
            end
            if (found) begin
                m_act[d] = 1; m_age[d] = 0; e_breq[d] = 1'b1;
            end
        end else begin
            m_age[d]++;
            if (slv_rdy[d] | slv_force[d]) begin
                mdl_finish(d, 1'b0);
                if (!e_rw[d]) e_rd[d][m_g[d]] = slv_rd[d];
            end else if (C_TO[d] != 0 && m_age[d] == C_TO[d]) begin
                mdl_finish(d, 1'b1);
                e_rd[d][m_g[d]] = '0;
            end
        end
    endfunction

    task automatic cmp(input int d);
        chk($sformatf("d%0d grant", d), 64'(gnt[d]), 64'(m_g[d]));
        chk($sformatf("d%0d bus_request", d), 64'(breq[d]), 64'(e_breq[d]));
        chk($sformatf("d%0d m_ready", d), 64'(m_rdy[d]), 64'(e_rdy[d]));
        chk($sformatf("d%0d m_error", d), 64'(m_err[d]), 64'(e_err[d]));
        for (int p = 0; p < NP; p++)
            chk($sformatf("d%0d rdata[%0d]", d, p), 64'(m_rd[d][p*32 +: 32]), 64'(e_rd[d][p]));
        if (e_breq[d]) begin
            chk($sformatf("d%0d bus_rw", d), 64'(brw[d]), 64'(e_rw[d]));
            chk($sformatf("d%0d bus_address", d), 64'(baddr[d]), 64'(e_addr[d]));
            chk($sformatf("d%0d bus_wdata", d), 64'(bwd[d]), 64'(e_wd[d]));
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) mdl_reset(d);
        forever begin
            @(posedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (rst[d]) mdl_reset(d);
                else mdl_step(d);
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst[d]) mdl_reset(d);
                cmp(d);
            end
        end
    end

    // Grant log taken on each rising bus request.
    initial begin
        forever begin
            @(negedge clk);
            if (breq[0] === 1'b1 && !bprev[0]) glog0.push_back(int'(gnt[0]));
            if (breq[1] === 1'b1 && !bprev[1]) begin
                glog1.push_back(int'(gnt[1]));
                rise1.push_back(cyc);
            end
            bprev[0] = breq[0];
            bprev[1] = breq[1];
        end
    end

    // Slave: ready during the slv_lat-th cycle of each bus request, never if slv_lat <= 0.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (breq[d] === 1'b1) begin
                    slv_cnt[d]++;
                    slv_rdy[d] = (slv_lat[d] > 0) && (slv_cnt[d] == slv_lat[d]);
                end else begin
                    slv_cnt[d] = 0;
                    slv_rdy[d] = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_ready(input int d, input int p, input int maxc,
                              output int busc, output bit errs);
        int n;
        n = 0;
        busc = breq[d] ? 1 : 0;
        errs = 1'b0;
        forever begin
            tick();
            n++;
            if (breq[d]) busc++;
            if (m_rdy[d][p]) begin
                errs = m_err[d][p];
                break;
            end
            if (n >= maxc) begin
                n_chk++;
                $display("FAIL wait_ready d%0d port %0d: no ready within %0d cycles", d, p, maxc);
                break;
            end
        end
    endtask

    int  busc;
    bit  errs;

    initial begin
        tick(); tick(); tick();
        chk("reset bus_request", 64'(breq[0]), 64'h0);
        chk("reset grant", 64'(gnt[1]), 64'h0);
        chk("reset rdata", 64'(m_rd[0][31:0]), 64'h0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        tick();

        // Single read on port 1.
        slv_lat[0] = 3;
        slv_rd[0]  = 32'hDEADBEEF;
        addr[0][32 +: 32] = 32'h10000004;
        req[0] = 3'b010;
        tick();
        chk("read latency bus_request", 64'(breq[0]), 64'h1);
        chk("read bus_address", 64'(baddr[0]), 64'h10000004);
        wait_ready(0, 1, 20, busc, errs);
        req[0] = 3'b000;
        chk("read bus cycles", 64'(busc), 64'd3);
        chk("read error", 64'(errs), 64'h0);
        chk("read rdata[1]", 64'(m_rd[0][32 +: 32]), 64'hDEADBEEF);
        chk("read rdata[0]", 64'(m_rd[0][0 +: 32]), 64'h0);
        chk("read rdata[2]", 64'(m_rd[0][64 +: 32]), 64'h0);
        tick();
        chk("read single pulse", 64'(m_rdy[0]), 64'h0);
        tick(); tick();

        // Fixed priority: port 0 keeps winning while it holds.
        slv_lat[0] = 2;
        slv_rd[0]  = 32'h12345678;
        glog0.delete();
        req[0] = 3'b111;
        for (int i = 0; i < 60 && glog0.size() < 3; i++) tick();
        req[0] = 3'b110;
        for (int i = 0; i < 60 && glog0.size() < 4; i++) tick();
        req[0] = 3'b000;
        repeat (8) tick();
        chk("fixed grant count", 64'(glog0.size()), 64'd4);
        if (glog0.size() >= 4) begin
            chk("fixed grant 0", 64'(glog0[0]), 64'd0);
            chk("fixed grant 1", 64'(glog0[1]), 64'd0);
            chk("fixed grant 2", 64'(glog0[2]), 64'd0);
            chk("fixed grant 3", 64'(glog0[3]), 64'd1);
        end
        chk("fixed rdata[1] after mid-busy drop", 64'(m_rd[0][32 +: 32]), 64'h12345678);
        chk("fixed rdata[2] never served", 64'(m_rd[0][64 +: 32]), 64'h0);

        // Timeout after 16 bus cycles, then the next pending port is served.
        slv_lat[0] = 0;
        glog0.delete();
        req[0] = 3'b011;
        wait_ready(0, 0, 40, busc, errs);
        req[0] = 3'b010;
        slv_lat[0] = 1;
        chk("timeout bus cycles", 64'(busc), 64'd16);
        chk("timeout error", 64'(errs), 64'h1);
        chk("timeout rdata[0]", 64'(m_rd[0][0 +: 32]), 64'h0);
        wait_ready(0, 1, 20, busc, errs);
        req[0] = 3'b000;
        chk("post-timeout error", 64'(errs), 64'h0);
        chk("post-timeout grant", 64'(glog0.size() >= 2 ? glog0[1] : -1), 64'd1);
        tick(); tick();

        // Ready while idle must be ignored.
        slv_force[0] = 1'b1;
        tick();
        chk("idle ready ignored", 64'(m_rdy[0]), 64'h0);
        tick();
        slv_force[0] = 1'b0;
        chk("idle ready no bus", 64'(breq[0]), 64'h0);
        tick();

        // Round-robin rotation.
        slv_lat[1] = 2;
        slv_rd[1]  = 32'hA5A50001;
        glog1.delete();
        rise1.delete();
        req[1] = 3'b111;
        for (int i = 0; i < 60 && glog1.size() < 4; i++) tick();
        req[1] = 3'b000;
        repeat (6) tick();
        chk("rr grant count", 64'(glog1.size()), 64'd4);
        if (glog1.size() >= 4) begin
            chk("rr grant 0", 64'(glog1[0]), 64'd0);
            chk("rr grant 1", 64'(glog1[1]), 64'd1);
            chk("rr grant 2", 64'(glog1[2]), 64'd2);
            chk("rr grant 3", 64'(glog1[3]), 64'd0);
            // Two bus cycles, the release cycle, then the arbitration cycle.
            chk("rr request period", 64'(rise1[1] - rise1[0]), 64'd4);
        end

        // Write on port 2 interrupted by reset.
        slv_lat[1] = 0;
        rw[1] = 3'b100;
        addr[1][64 +: 32] = 32'h40000000;
        wdat[1][64 +: 32] = 32'h00000005;
        req[1] = 3'b100;
        tick();
        chk("write bus_rw", 64'(brw[1]), 64'h1);
        chk("write bus_address", 64'(baddr[1]), 64'h40000000);
        chk("write bus_wdata", 64'(bwd[1]), 64'h5);
        repeat (3) tick();
        rst[1] = 1'b1;
        #1;
        chk("async reset bus_request", 64'(breq[1]), 64'h0);
        chk("async reset grant", 64'(gnt[1]), 64'h0);
        chk("async reset no ready", 64'(m_rdy[1]), 64'h0);
        req[1] = 3'b101;
        rw[1]  = 3'b000;
        tick(); tick();
        glog1.delete();
        slv_lat[1] = 2;
        rst[1] = 1'b0;
        wait_ready(1, 0, 20, busc, errs);
        req[1] = 3'b100;
        chk("pointer restart grant", 64'(glog1.size() >= 1 ? glog1[0] : -1), 64'd0);
        wait_ready(1, 2, 20, busc, errs);
        req[1] = 3'b000;
        chk("after reset next grant", 64'(glog1.size() >= 2 ? glog1[1] : -1), 64'd2);
        chk("after reset rdata[2]", 64'(m_rd[1][64 +: 32]), 64'hA5A50001);
        tick(); tick();

        // Ready on the same cycle the timeout would fire.
        slv_lat[1] = 8;
        slv_rd[1]  = 32'hCAFEF00D;
        req[1] = 3'b010;
        wait_ready(1, 1, 30, busc, errs);
        req[1] = 3'b000;
        chk("coincide bus cycles", 64'(busc), 64'd8);
        chk("coincide error", 64'(errs), 64'h0);
        chk("coincide rdata[1]", 64'(m_rd[1][32 +: 32]), 64'hCAFEF00D);
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
